// File: rtl/hilo_muldiv_ctrl_if.sv
// Bus between the HI/LO sequencer and the iterative multiply/divide units.
// The sequencer owns the master side; the unit pair (or a bench stub) owns the slave side.
interface hilo_muldiv_ctrl_if;
  logic        u_reset;
  logic        div_go;
  logic        mult_go;
  logic [31:0] u_x;
  logic [31:0] u_y;
  logic        div_fim;
  logic        div_zero;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        mult_done;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;

  modport master (
    output u_reset, div_go, mult_go, u_x, u_y,
    input  div_fim, div_zero, div_hi, div_lo, mult_done, mult_hi, mult_lo
  );

  modport slave (
    input  u_reset, div_go, mult_go, u_x, u_y,
    output div_fim, div_zero, div_hi, div_lo, mult_done, mult_hi, mult_lo
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Sequencer between the multicycle control unit and the iterative mult/div units.
// Latches operands on start, clears and launches the selected unit, waits for a trusted
// completion, then writes HI/LO. Also services mthi/mtlo while idle.
module hilo_muldiv_ctrl #(
  parameter int unsigned DIV_MIN_LAT  = 33,
  parameter int unsigned MULT_MIN_LAT = 1,
  // Must exceed both MIN_LAT values, otherwise a slow unit always times out.
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        timeout_err,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  hilo_muldiv_ctrl_if.master unit
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StRun,
    StWb,
    StErr,
    StTo
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   run_cnt;
  logic              op_q;
  logic [31:0]       ux_q, uy_q;
  logic [31:0]       hold_hi_q, hold_lo_q;
  logic              cap_en;
  logic              sel_done;

  // cnt_q counts RUN cycles already completed, so run_cnt is the 1-based index of the
  // current RUN cycle; a done flag is trusted once that index reaches the unit's MIN_LAT.
  assign run_cnt  = cnt_q + CntW'(1);
  assign sel_done = op_q ? (unit.div_fim   && (run_cnt >= CntW'(DIV_MIN_LAT)))
                         : (unit.mult_done && (run_cnt >= CntW'(MULT_MIN_LAT)));

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StClr;
      end
      StClr: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = run_cnt;
        if (op_q && unit.div_zero) begin
          state_d = StErr;
        end else if (sel_done) begin
          state_d = StWb;
          cap_en  = 1'b1;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StTo;
        end
      end
      StWb, StErr, StTo: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand latches, result holding regs and the architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= 1'b0;
      ux_q      <= '0;
      uy_q      <= '0;
      hold_hi_q <= '0;
      hold_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        op_q <= op;
        ux_q <= a;
        uy_q <= b;
      end
      if (cap_en) begin
        hold_hi_q <= op_q ? unit.div_hi : unit.mult_hi;
        hold_lo_q <= op_q ? unit.div_lo : unit.mult_lo;
      end
      if (state_q == StWb) begin
        hi_q <= hold_hi_q;
        lo_q <= hold_lo_q;
      end else if (state_q == StIdle) begin
        if (mthi) hi_q <= wdata;
        if (mtlo) lo_q <= wdata;
      end
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StWb);
  assign div_by_zero = (state_q == StErr);
  assign timeout_err = (state_q == StTo);

  // Units are held in reset while this block is reset as well as during CLR.
  assign unit.u_reset = reset || (state_q == StClr);
  assign unit.div_go  = (state_q == StRun) && op_q;
  assign unit.mult_go = (state_q == StRun) && !op_q;
  assign unit.u_x     = ux_q;
  assign unit.u_y     = uy_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: a per-cycle vector table for the idle-side writes
// and a short mult, then hand-written sequences for the multi-cycle corner cases.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy, done, div_by_zero, timeout_err;
  logic [31:0] hi_q, lo_q;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_ctrl_if u_if ();

  hilo_muldiv_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .timeout_err (timeout_err),
    .hi_q        (hi_q),
    .lo_q        (lo_q),
    .unit        (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        st;
    logic        opv;
    logic [31:0] av;
    logic [31:0] bv;
    logic        wh;
    logic        wl;
    logic [31:0] wd;
    logic        mdone;
    logic [31:0] mhi;
    logic [31:0] mlo;
    logic        e_busy;
    logic        e_done;
    logic        e_ureset;
    logic        e_mgo;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs from the first sample after a start edge until busy drops, tallying pulses.
  task automatic run_to_idle(input int inj, input logic [31:0] ex, input logic [31:0] ey,
                             output int nb, output int nd, output int nz, output int nt,
                             output int ng, output int nux);
    nb = 0; nd = 0; nz = 0; nt = 0; ng = 0; nux = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      nb++;
      nd += int'(done);
      nz += int'(div_by_zero);
      nt += int'(timeout_err);
      ng += int'(u_if.div_go | u_if.mult_go);
      if (u_if.u_x !== ex || u_if.u_y !== ey) nux++;
      if (i == inj) begin
        start = 1'b1; a = 32'h999; b = 32'h888;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic launch(input logic opv, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; op = opv; a = av; b = bv;
    step();
    start = 1'b0;
  endtask

  int nb, nd, nz, nt, ng, nux;

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    u_if.div_fim = 1'b0; u_if.div_zero = 1'b0; u_if.div_hi = '0; u_if.div_lo = '0;
    u_if.mult_done = 1'b0; u_if.mult_hi = '0; u_if.mult_lo = '0;

    //          name         rst st op a  b  wh wl wd            md mhi           mlo
    //                       busy done urst mgo hi            lo
    vecs[0]  = '{"reset",     1, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0,
                              0, 0, 1, 0, 32'h0,         32'h0};
    vecs[1]  = '{"idle",      0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0,
                              0, 0, 0, 0, 32'h0,         32'h0};
    vecs[2]  = '{"mthilo",    0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0,
                              0, 0, 0, 0, 32'hDEADBEEF,  32'hDEADBEEF};
    vecs[3]  = '{"mthi",      0, 0, 0, 0, 0, 1, 0, 32'h11111111, 0, 0, 0,
                              0, 0, 0, 0, 32'h11111111,  32'hDEADBEEF};
    vecs[4]  = '{"mtlo",      0, 0, 0, 0, 0, 0, 1, 32'h22222222, 0, 0, 0,
                              0, 0, 0, 0, 32'h11111111,  32'h22222222};
    vecs[5]  = '{"m_start",   0, 1, 0, 3, 5, 0, 0, 0,           1, 32'h0, 32'hF,
                              1, 0, 1, 0, 32'h11111111,  32'h22222222};
    vecs[6]  = '{"m_run",     0, 0, 0, 0, 0, 0, 0, 0,           1, 32'h0, 32'hF,
                              1, 0, 0, 1, 32'h11111111,  32'h22222222};
    vecs[7]  = '{"m_wb_busyw",0, 0, 0, 0, 0, 1, 1, 32'hBAD0BAD0, 1, 32'h0, 32'hF,
                              1, 1, 0, 0, 32'h11111111,  32'h22222222};
    vecs[8]  = '{"m_idle",    0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0,
                              0, 0, 0, 0, 32'h0,         32'hF};
    vecs[9]  = '{"st_and_mt", 0, 1, 0, 1, 2, 1, 1, 32'h5A5A5A5A, 1, 32'h01234567, 32'h89ABCDEF,
                              1, 0, 1, 0, 32'h5A5A5A5A,  32'h5A5A5A5A};
    vecs[10] = '{"st_run",    0, 0, 0, 0, 0, 0, 0, 0,           1, 32'h01234567, 32'h89ABCDEF,
                              1, 0, 0, 1, 32'h5A5A5A5A,  32'h5A5A5A5A};
    vecs[11] = '{"st_wb",     0, 0, 0, 0, 0, 0, 0, 0,           1, 32'h01234567, 32'h89ABCDEF,
                              1, 1, 0, 0, 32'h5A5A5A5A,  32'h5A5A5A5A};
    vecs[12] = '{"st_idle",   0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0,
                              0, 0, 0, 0, 32'h01234567,  32'h89ABCDEF};

    for (int i = 0; i < 13; i++) begin
      reset = vecs[i].rst; start = vecs[i].st; op = vecs[i].opv;
      a = vecs[i].av; b = vecs[i].bv;
      mthi = vecs[i].wh; mtlo = vecs[i].wl; wdata = vecs[i].wd;
      u_if.mult_done = vecs[i].mdone; u_if.mult_hi = vecs[i].mhi; u_if.mult_lo = vecs[i].mlo;
      step();
      chk({vecs[i].name, ".busy"},   busy,          vecs[i].e_busy);
      chk({vecs[i].name, ".done"},   done,          vecs[i].e_done);
      chk({vecs[i].name, ".ureset"}, u_if.u_reset,  vecs[i].e_ureset);
      chk({vecs[i].name, ".mgo"},    u_if.mult_go,  vecs[i].e_mgo);
      chk({vecs[i].name, ".hi"},     hi_q,          vecs[i].e_hi);
      chk({vecs[i].name, ".lo"},     lo_q,          vecs[i].e_lo);
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; u_if.mult_done = 1'b0;

    // Stale div_fim must be ignored until the 33rd RUN cycle.
    u_if.div_fim = 1'b1; u_if.div_zero = 1'b0; u_if.div_hi = 32'h2; u_if.div_lo = 32'hE;
    launch(1'b1, 32'd100, 32'd7);
    run_to_idle(-1, 32'd100, 32'd7, nb, nd, nz, nt, ng, nux);
    chk("div.busy_cycles", nb, 35);
    chk("div.done_pulses", nd, 1);
    chk("div.go_cycles",   ng, 33);
    chk("div.uxy_stable",  nux, 0);
    chk("div.hi",          hi_q, 32'h2);
    chk("div.lo",          lo_q, 32'hE);
    u_if.div_fim = 1'b0;

    // Divide by zero flagged on the 2nd RUN cycle.
    mthi = 1'b1; wdata = 32'hAAAA5555; step();
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h12345678; step();
    mtlo = 1'b0;
    launch(1'b1, 32'd9, 32'd0);
    step();
    step();
    u_if.div_zero = 1'b1;
    step();
    chk("dbz.pulse", div_by_zero, 1'b1);
    chk("dbz.done",  done,        1'b0);
    u_if.div_zero = 1'b0;
    step();
    chk("dbz.busy_after", busy,        1'b0);
    chk("dbz.pulse_gone", div_by_zero, 1'b0);
    chk("dbz.hi",         hi_q,        32'hAAAA5555);
    chk("dbz.lo",         lo_q,        32'h12345678);

    // Multiplier that never finishes; also try HI/LO writes while busy.
    u_if.mult_done = 1'b0;
    launch(1'b0, 32'd4, 32'd6);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hFFFFFFFF;
    run_to_idle(-1, 32'd4, 32'd6, nb, nd, nz, nt, ng, nux);
    mthi = 1'b0; mtlo = 1'b0;
    chk("to.busy_cycles", nb, 66);
    chk("to.pulses",      nt, 1);
    chk("to.done_pulses", nd, 0);
    chk("to.go_cycles",   ng, 64);
    chk("to.hi",          hi_q, 32'hAAAA5555);
    chk("to.lo",          lo_q, 32'h12345678);
    u_if.mult_done = 1'b1; u_if.mult_hi = 32'h77; u_if.mult_lo = 32'h88;
    launch(1'b0, 32'd1, 32'd1);
    chk("to.next_start", busy, 1'b1);
    run_to_idle(-1, 32'd1, 32'd1, nb, nd, nz, nt, ng, nux);
    chk("to.next_hi", hi_q, 32'h77);
    chk("to.next_lo", lo_q, 32'h88);
    u_if.mult_done = 1'b0;

    // Reset during RUN cycle 10.
    launch(1'b1, 32'd50, 32'd5);
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    #1;
    chk("rst.ureset_comb", u_if.u_reset, 1'b1);
    step();
    chk("rst.busy",   busy,          1'b0);
    chk("rst.hi",     hi_q,          32'h0);
    chk("rst.lo",     lo_q,          32'h0);
    chk("rst.pulses", {done, div_by_zero, timeout_err}, 3'b000);
    chk("rst.ureset", u_if.u_reset, 1'b1);
    reset = 1'b0;
    step();
    chk("rst.ureset_rel", u_if.u_reset, 1'b0);
    chk("rst.pulses2",    {busy, done, div_by_zero, timeout_err}, 4'b0000);

    // Second start during RUN must be dropped.
    u_if.div_fim = 1'b1; u_if.div_hi = 32'h33; u_if.div_lo = 32'h44;
    launch(1'b1, 32'd100, 32'd7);
    run_to_idle(5, 32'd100, 32'd7, nb, nd, nz, nt, ng, nux);
    chk("dbl.done_pulses", nd, 1);
    chk("dbl.uxy_stable",  nux, 0);
    chk("dbl.busy_cycles", nb, 35);
    chk("dbl.hi",          hi_q, 32'h33);
    chk("dbl.lo",          lo_q, 32'h44);
    step();
    step();
    chk("dbl.no_relaunch", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
